// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and the IF/ID handshake towards decode.
// The fetch stage connects to the master modport, and memory/decode connect to the slave modport.
interface instruction_fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr, if_valid, if_pc, if_pc_plus4, if_instr, fetch_fault, fetch_count,
    input  imem_instr, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_addr, if_valid, if_pc, if_pc_plus4, if_instr, fetch_fault, fetch_count,
    output imem_instr, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// RISC-V fetch stage: owns the PC, reads the combinational instruction memory and fills the IF/ID slot.
// Optional macro FETCH_FAULT_EN enables misaligned/out-of-range fault slots and the halted state.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  instruction_fetch_if.master bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] r_pc, r_if_pc, r_if_instr, r_fetch_count;
  logic        r_if_valid;
  logic [31:0] w_pc_next, w_if_pc_next, w_if_instr_next, w_fetch_count_next;
  logic        w_if_valid_next, w_advance, w_accept;

`ifdef FETCH_FAULT_EN
  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);
  logic r_fault, r_halted, w_fault_next, w_halted_next, w_fault;
  assign w_fault = (r_pc[1:0] != 2'b00) || (r_pc >= IMEM_BYTES);
`endif

  assign w_advance = !r_if_valid || bus.if_ready;
  assign w_accept  = r_if_valid && bus.if_ready;

  // NOTE: every next-state signal gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    w_pc_next          = r_pc;
    w_if_valid_next    = r_if_valid;
    w_if_pc_next       = r_if_pc;
    w_if_instr_next    = r_if_instr;
    w_fetch_count_next = r_fetch_count + 32'(w_accept);
`ifdef FETCH_FAULT_EN
    w_fault_next       = r_fault;
    w_halted_next      = r_halted;
    if (bus.redirect_valid) begin
      w_pc_next       = bus.redirect_pc;
      w_if_valid_next = 1'b0;
      w_fault_next    = 1'b0;
      w_halted_next   = 1'b0;
    end else if (r_halted) begin
      if (w_accept) w_if_valid_next = 1'b0;
    end else if (w_advance) begin
      w_if_valid_next = 1'b1;
      w_if_pc_next    = r_pc;
      if (w_fault) begin
        // The PC stays on the faulting address so the handler can see where fetch stopped.
        w_if_instr_next = NOP;
        w_fault_next    = 1'b1;
        w_halted_next   = 1'b1;
      end else begin
        w_if_instr_next = bus.imem_instr;
        w_fault_next    = 1'b0;
        w_pc_next       = r_pc + 32'd4;
      end
    end
`else
    if (bus.redirect_valid) begin
      w_pc_next       = bus.redirect_pc & ~32'd3;
      w_if_valid_next = 1'b0;
    end else if (w_advance) begin
      w_if_valid_next = 1'b1;
      w_if_pc_next    = r_pc;
      w_if_instr_next = bus.imem_instr;
      w_pc_next       = r_pc + 32'd4;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_if_valid    <= 1'b0;
      r_if_pc       <= 32'h0;
      r_if_instr    <= NOP;
      r_fetch_count <= 32'h0;
    end else begin
      r_pc          <= w_pc_next;
      r_if_valid    <= w_if_valid_next;
      r_if_pc       <= w_if_pc_next;
      r_if_instr    <= w_if_instr_next;
      r_fetch_count <= w_fetch_count_next;
    end
  end

`ifdef FETCH_FAULT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_fault  <= w_fault_next;
      r_halted <= w_halted_next;
    end
  end
  assign bus.fetch_fault = r_fault;
`else
  assign bus.fetch_fault = 1'b0;
`endif

  assign bus.imem_addr   = r_pc;
  assign bus.if_valid    = r_if_valid;
  assign bus.if_pc       = r_if_pc;
  assign bus.if_pc_plus4 = r_if_pc + 32'd4;
  assign bus.if_instr    = r_if_instr;
  assign bus.fetch_count = r_fetch_count;
endmodule
